lpc_pcm_player: RTL and testbench

- Downstream stage of lpc_decoder: an AXI-stream style sink for the 16-bit decoded samples (OUT_DECODED/OUT_VALID/OUT_READY/OUT_LAST).
- Buffers samples in a FIFO and primes before starting playback.
- Releases one sample per sample-rate tick to the PCM/DAC interface, re-timing bursty decoder output to a fixed audio rate.
- Flags underruns and marks utterance boundaries.

---
 rtl/lpc_pkg.sv | 17 +
 rtl/lpc_sample_fifo.sv | 60 ++++++
 rtl/lpc_pcm_player.sv | 128 ++++++++++++
 tb/tb_lpc_pcm_player.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC widths, player state encoding and helpers
package lpc_pkg;

    localparam int LPC_SAMPLE_W   = 16;
    localparam int LPC_FRAME_W    = 80;
    localparam int LPC_UNDERRUN_W = 16;

    typedef enum logic {
        PLAYER_IDLE = 1'b0,
        PLAYER_PLAY = 1'b1
    } player_state_t;

    function automatic logic [LPC_UNDERRUN_W-1:0] sat_inc(input logic [LPC_UNDERRUN_W-1:0] v);
        return (&v) ? v : v + LPC_UNDERRUN_W'(1);
    endfunction

endpackage

// File: rtl/lpc_sample_fifo.sv
// rtl/lpc_sample_fifo.sv - synchronous sample FIFO with count, full/empty and head
module lpc_sample_fifo
    import lpc_pkg::*;
#(
    parameter int W     = LPC_SAMPLE_W + 1,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          ACLK,
    input  logic          ARESET_N,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: a cleared count makes stale entries unreachable.
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lpc_pcm_player.sv
// rtl/lpc_pcm_player.sv - buffers decoded samples and releases one per sample tick
module lpc_pcm_player
    import lpc_pkg::*;
#(
    parameter int DATA_W      = LPC_SAMPLE_W,
    parameter int DEPTH       = 64,
    parameter int PRIME_LEVEL = 32,
    parameter int CLK_DIV     = 12500
) (
    input  logic                      ACLK,
    input  logic                      ARESET_N,
    input  logic [DATA_W-1:0]         IN_DECODED,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      IN_LAST,
    output logic [DATA_W-1:0]         PCM_DATA,
    output logic                      PCM_STROBE,
    output logic                      PCM_LAST,
    output logic                      UNDERRUN,
    output logic [LPC_UNDERRUN_W-1:0] UNDERRUN_CNT,
    output logic [$clog2(DEPTH):0]    FILL_LEVEL,
    output logic                      PLAYING
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    player_state_t    state_q;
    player_state_t    state_d;
    logic [DIV_W-1:0] tick_cnt;
    logic [CW-1:0]    last_pending;
    logic [CW-1:0]    fifo_count;
    logic [DATA_W:0]  head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ready_q;
    logic             push;
    logic             pop;
    logic             tick;
    logic             head_last;

    lpc_sample_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ACLK      (ACLK),
        .ARESET_N  (ARESET_N),
        .push      (push),
        .push_data ({IN_LAST, IN_DECODED}),
        .pop       (pop),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // ready_q holds IN_READY low until the first edge after reset release.
    assign IN_READY   = ready_q && !fifo_full;
    assign push       = IN_VALID && IN_READY;
    assign tick       = (state_q == PLAYER_PLAY) && (tick_cnt == DIV_W'(CLK_DIV - 1));
    assign pop        = tick && !fifo_empty;
    assign head_last  = head[DATA_W];
    assign FILL_LEVEL = fifo_count;
    assign PLAYING    = (state_q == PLAYER_PLAY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAYER_IDLE: begin
                if ((fifo_count >= CW'(PRIME_LEVEL)) || (last_pending != '0)) begin
                    state_d = PLAYER_PLAY;
                end
            end
            PLAYER_PLAY: begin
                // Leave once the end-of-utterance strobe has been presented.
                if (PCM_STROBE && PCM_LAST) begin
                    state_d = PLAYER_IDLE;
                end
            end
            default: state_d = PLAYER_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state_q      <= PLAYER_IDLE;
            tick_cnt     <= '0;
            last_pending <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if ((state_q == PLAYER_PLAY) && (state_d == PLAYER_PLAY)) begin
                tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
            end else begin
                tick_cnt <= '0;
            end
            case ({push && IN_LAST, pop && head_last})
                2'b10:   last_pending <= last_pending + CW'(1);
                2'b01:   last_pending <= last_pending - CW'(1);
                default: last_pending <= last_pending;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            PCM_DATA     <= '0;
            PCM_STROBE   <= 1'b0;
            PCM_LAST     <= 1'b0;
            UNDERRUN     <= 1'b0;
            UNDERRUN_CNT <= '0;
        end else begin
            PCM_STROBE <= tick;
            PCM_LAST   <= pop && head_last;
            UNDERRUN   <= tick && fifo_empty;
            if (pop) begin
                PCM_DATA <= head[DATA_W-1:0];
            end else if (tick) begin
                PCM_DATA <= '0;
            end
            if (tick && fifo_empty) begin
                UNDERRUN_CNT <= sat_inc(UNDERRUN_CNT);
            end
        end
    end

endmodule

// File: tb/tb_lpc_pcm_player.sv
// tb/tb_lpc_pcm_player.sv - directed self-checking bench for lpc_pcm_player
module tb_lpc_pcm_player;

    logic        ACLK = 1'b0;
    logic        ARESET_N = 1'b0;

    logic [15:0] in_decoded = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] pcm_data;
    logic        pcm_strobe;
    logic        pcm_last;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [3:0]  fill_level;
    logic        playing;

    logic [15:0] b_decoded = '0;
    logic        b_valid = 1'b0;
    logic        b_last = 1'b0;
    logic        b_ready;
    logic [15:0] b_data;
    logic        b_strobe;
    logic        b_pcm_last;
    logic        b_underrun;
    logic [15:0] b_ucnt;
    logic [3:0]  b_fill;
    logic        b_playing;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    lpc_pcm_player #(.DATA_W(16), .DEPTH(8), .PRIME_LEVEL(4), .CLK_DIV(4)) dut (
        .ACLK(ACLK), .ARESET_N(ARESET_N),
        .IN_DECODED(in_decoded), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_LAST(in_last),
        .PCM_DATA(pcm_data), .PCM_STROBE(pcm_strobe), .PCM_LAST(pcm_last),
        .UNDERRUN(underrun), .UNDERRUN_CNT(underrun_cnt), .FILL_LEVEL(fill_level),
        .PLAYING(playing)
    );

    lpc_pcm_player #(.DATA_W(16), .DEPTH(8), .PRIME_LEVEL(4), .CLK_DIV(16)) dut16 (
        .ACLK(ACLK), .ARESET_N(ARESET_N),
        .IN_DECODED(b_decoded), .IN_VALID(b_valid), .IN_READY(b_ready), .IN_LAST(b_last),
        .PCM_DATA(b_data), .PCM_STROBE(b_strobe), .PCM_LAST(b_pcm_last),
        .UNDERRUN(b_underrun), .UNDERRUN_CNT(b_ucnt), .FILL_LEVEL(b_fill),
        .PLAYING(b_playing)
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET_N = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_decoded = '0;
        b_valid = 1'b0; b_last = 1'b0; b_decoded = '0;
        repeat (3) step();
        ARESET_N = 1'b1;
        step();
    endtask

    task automatic test_reset();
        int strobes;
        int saw_play;
        ARESET_N = 1'b0;
        #2;
        repeat (2) step();
        ARESET_N = 1'b1;
        step();
        checks++; if (pcm_data !== 16'h0) begin failures++; $display("FAIL reset_pcm_data got=%h exp=0000", pcm_data); end
        checks++; if (pcm_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", pcm_strobe); end
        checks++; if (pcm_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", pcm_last); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL reset_ucnt got=%h exp=0000", underrun_cnt); end
        checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%b exp=0", playing); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        strobes = 0; saw_play = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (pcm_strobe === 1'b1) strobes++;
            if (playing === 1'b1) saw_play++;
        end
        checks++; if (strobes != 0) begin failures++; $display("FAIL idle_strobes got=%0d exp=0", strobes); end
        checks++; if (saw_play != 0) begin failures++; $display("FAIL idle_playing got=%0d exp=0", saw_play); end
    endtask

    task automatic test_prime_play();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_decoded = 16'(i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (fill_level !== 4'd4) begin failures++; $display("FAIL prime_fill got=%0d exp=4", fill_level); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL prime_not_yet got=%b exp=0", playing); end
        step();
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL prime_playing got=%b exp=1", playing); end
        for (int k = 0; k < 4; k++) begin
            for (int j = 1; j <= 4; j++) begin
                step();
                checks++;
                if (pcm_strobe !== (j == 4)) begin
                    failures++; $display("FAIL play_strobe k=%0d j=%0d got=%b exp=%b", k, j, pcm_strobe, (j == 4));
                end
            end
            checks++; if (pcm_data !== 16'(k + 1)) begin failures++; $display("FAIL play_data k=%0d got=%h exp=%h", k, pcm_data, 16'(k + 1)); end
            checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL play_underrun k=%0d got=%b exp=0", k, underrun); end
        end
    endtask

    task automatic test_underrun();
        repeat (4) step();
        checks++; if (pcm_strobe !== 1'b1) begin failures++; $display("FAIL ur_strobe got=%b exp=1", pcm_strobe); end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_flag got=%b exp=1", underrun); end
        checks++; if (pcm_data !== 16'h0) begin failures++; $display("FAIL ur_data got=%h exp=0000", pcm_data); end
        checks++; if (underrun_cnt !== 16'd1) begin failures++; $display("FAIL ur_cnt got=%0d exp=1", underrun_cnt); end
        in_valid = 1'b1; in_decoded = 16'h1234;
        step();
        in_valid = 1'b0;
        checks++; if (fill_level !== 4'd1) begin failures++; $display("FAIL ur_fill got=%0d exp=1", fill_level); end
        repeat (3) step();
        checks++; if (pcm_strobe !== 1'b1) begin failures++; $display("FAIL resume_strobe got=%b exp=1", pcm_strobe); end
        checks++; if (pcm_data !== 16'h1234) begin failures++; $display("FAIL resume_data got=%h exp=1234", pcm_data); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL resume_underrun got=%b exp=0", underrun); end
        checks++; if (underrun_cnt !== 16'd1) begin failures++; $display("FAIL resume_cnt got=%0d exp=1", underrun_cnt); end
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL resume_playing got=%b exp=1", playing); end
    endtask

    task automatic test_last_prime();
        do_reset();
        in_valid = 1'b1; in_decoded = 16'h00AA; in_last = 1'b0;
        step();
        in_decoded = 16'h00BB; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (fill_level !== 4'd2) begin failures++; $display("FAIL last_fill got=%0d exp=2", fill_level); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL last_not_yet got=%b exp=0", playing); end
        step();
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL last_playing got=%b exp=1", playing); end
        repeat (4) step();
        checks++; if (pcm_strobe !== 1'b1) begin failures++; $display("FAIL last_s1_strobe got=%b exp=1", pcm_strobe); end
        checks++; if (pcm_data !== 16'h00AA) begin failures++; $display("FAIL last_s1_data got=%h exp=00aa", pcm_data); end
        checks++; if (pcm_last !== 1'b0) begin failures++; $display("FAIL last_s1_last got=%b exp=0", pcm_last); end
        repeat (4) step();
        checks++; if (pcm_strobe !== 1'b1) begin failures++; $display("FAIL last_s2_strobe got=%b exp=1", pcm_strobe); end
        checks++; if (pcm_data !== 16'h00BB) begin failures++; $display("FAIL last_s2_data got=%h exp=00bb", pcm_data); end
        checks++; if (pcm_last !== 1'b1) begin failures++; $display("FAIL last_s2_last got=%b exp=1", pcm_last); end
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL last_s2_playing got=%b exp=1", playing); end
        step();
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL last_end_playing got=%b exp=0", playing); end
        checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL last_end_fill got=%0d exp=0", fill_level); end
        checks++; if (pcm_strobe !== 1'b0) begin failures++; $display("FAIL last_end_strobe got=%b exp=0", pcm_strobe); end
    endtask

    task automatic test_backpressure();
        logic [15:0] outs [12];
        int next_in;
        int nout;
        int saw_full;
        logic acc;
        logic exp_ready;
        do_reset();
        next_in = 1; nout = 0; saw_full = 0;
        b_valid = 1'b1; b_decoded = 16'd1;
        for (int cyc = 0; cyc < 800 && nout < 12; cyc++) begin
            acc = b_valid && b_ready;
            step();
            if (acc) begin
                next_in++;
                if (next_in > 12) b_valid = 1'b0;
                else b_decoded = 16'(next_in);
            end
            exp_ready = (b_fill != 4'd8);
            checks++;
            if (b_ready !== exp_ready) begin
                failures++; $display("FAIL bp_ready cyc=%0d fill=%0d got=%b exp=%b", cyc, b_fill, b_ready, exp_ready);
            end
            if (b_fill == 4'd8) saw_full = 1;
            if (b_strobe === 1'b1) begin
                outs[nout] = b_data;
                nout++;
            end
        end
        b_valid = 1'b0;
        checks++; if (nout != 12) begin failures++; $display("FAIL bp_count got=%0d exp=12", nout); end
        checks++; if (saw_full != 1) begin failures++; $display("FAIL bp_saw_full got=%0d exp=1", saw_full); end
        checks++; if (b_ucnt !== 16'd0) begin failures++; $display("FAIL bp_ucnt got=%0d exp=0", b_ucnt); end
        for (int i = 0; i < nout; i++) begin
            checks++;
            if (outs[i] !== 16'(i + 1)) begin
                failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, outs[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_midreset();
        int waited;
        int strobes;
        int saw_play;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_decoded = 16'(16'h10 + i);
            step();
        end
        in_valid = 1'b0;
        waited = 0;
        while (pcm_strobe !== 1'b1 && waited < 50) begin
            step(); waited++;
        end
        checks++; if (waited >= 50) begin failures++; $display("FAIL mr_first_strobe got=timeout exp=strobe"); end
        checks++; if (pcm_data !== 16'h0010) begin failures++; $display("FAIL mr_pre_data got=%h exp=0010", pcm_data); end
        checks++; if (fill_level !== 4'd5) begin failures++; $display("FAIL mr_pre_fill got=%0d exp=5", fill_level); end
        #3;
        ARESET_N = 1'b0;
        #1;
        checks++; if (pcm_data !== 16'h0) begin failures++; $display("FAIL mr_async_data got=%h exp=0000", pcm_data); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL mr_async_playing got=%b exp=0", playing); end
        checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL mr_async_fill got=%0d exp=0", fill_level); end
        checks++; if (pcm_strobe !== 1'b0) begin failures++; $display("FAIL mr_async_strobe got=%b exp=0", pcm_strobe); end
        repeat (3) step();
        ARESET_N = 1'b1;
        strobes = 0; saw_play = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pcm_strobe === 1'b1) strobes++;
            if (playing === 1'b1) saw_play++;
        end
        checks++; if (strobes != 0) begin failures++; $display("FAIL mr_quiet_strobes got=%0d exp=0", strobes); end
        checks++; if (saw_play != 0) begin failures++; $display("FAIL mr_quiet_playing got=%0d exp=0", saw_play); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_decoded = 16'(16'h50 + i);
            step();
        end
        in_valid = 1'b0;
        waited = 0;
        while (pcm_strobe !== 1'b1 && waited < 50) begin
            step(); waited++;
        end
        checks++; if (waited >= 50) begin failures++; $display("FAIL mr_post_strobe got=timeout exp=strobe"); end
        checks++; if (pcm_data !== 16'h0050) begin failures++; $display("FAIL mr_post_data got=%h exp=0050", pcm_data); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL mr_post_underrun got=%b exp=0", underrun); end
    endtask

    initial begin
        test_reset();
        test_prime_play();
        test_underrun();
        test_last_prime();
        test_backpressure();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
